// File: rtl/charlieplex_scan.sv
// charlieplex_scan
//   Wishbone-slave driver for a 7-pin charlieplexed LED matrix
//   (7 anode rows x 6 cathode columns = 42 LEDs). Holds a 7-row
//   framebuffer plus a global brightness register, scans one row per
//   256 PWM steps, blanks on step 0 and dims by blanking steps above
//   the brightness value.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   wb_cyc/wb_stb  Wishbone cycle / strobe
//   wb_we          write enable
//   wb_adr[2:0]    0..6 = row framebuffer (6 valid bits), 7 = brightness
//   wb_dat_i[7:0]  write data
//   wb_dat_o[7:0]  read data, valid while wb_ack is high, held otherwise
//   wb_ack         one-cycle acknowledge per strobe
//   charlieplex_oe per-pin output enable (0 = hi-Z), registered
//   charlieplex_o  per-pin drive level, registered
module charlieplex_scan #(
    parameter int         TICKS_PER_STEP   = 16,
    parameter logic [7:0] BRIGHTNESS_RESET = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_cyc,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic [2:0] wb_adr,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack,
    output logic [6:0] charlieplex_oe,
    output logic [6:0] charlieplex_o
);

    localparam int            PW      = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_STEP - 1);

    logic [5:0]    r_row [0:6];
    logic [7:0]    r_bright;
    logic          r_done;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_step;
    logic [2:0]    r_scan_row;
    logic [5:0]    r_shadow;

    logic          w_req;
    logic          w_tick;
    logic          w_row_wrap;
    logic [2:0]    w_row_next;
    logic [7:0]    w_rd_data;
    logic [6:0]    w_oe;
    logic [6:0]    w_o;

    // r_done remembers that the current strobe was already acknowledged,
    // so a master holding stb across several cycles gets exactly one ack.
    assign w_req      = wb_cyc & wb_stb & ~wb_ack & ~r_done;
    assign w_tick     = (r_pre == PRE_MAX);
    assign w_row_wrap = w_tick && (r_step == 8'hFF);
    assign w_row_next = (r_scan_row == 3'd6) ? 3'd0 : r_scan_row + 3'd1;

    always_comb begin
        w_rd_data = 8'h00;
        if (wb_adr == 3'd7) begin
            w_rd_data = r_bright;
        end else begin
            w_rd_data = {2'b00, r_row[wb_adr]};
        end
    end

    // Pin pattern for the current step/row; registered below so the pins
    // change one clock after the scan state.
    always_comb begin
        logic [2:0] j;
        logic [7:0] sh;
        w_oe = '0;
        w_o  = '0;
        j    = '0;
        sh   = {2'b00, r_shadow};
        if (r_step != 8'd0 && r_step <= r_bright) begin
            for (int p = 0; p < 7; p++) begin
                if (p == int'(r_scan_row)) begin
                    w_oe[p] = 1'b1;
                    w_o[p]  = 1'b1;
                end else begin
                    // Column j skips over the anode pin of this row.
                    j       = (p < int'(r_scan_row)) ? 3'(p) : 3'(p - 1);
                    w_oe[p] = sh[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) begin
                r_row[k] <= '0;
            end
            r_bright       <= BRIGHTNESS_RESET;
            r_done         <= 1'b0;
            wb_ack         <= 1'b0;
            wb_dat_o       <= '0;
            r_pre          <= '0;
            r_step         <= '0;
            r_scan_row     <= '0;
            r_shadow       <= '0;
            charlieplex_oe <= '0;
            charlieplex_o  <= '0;
        end else begin
            wb_ack <= w_req;
            r_done <= (wb_cyc & wb_stb) ? (r_done | w_req) : 1'b0;
            if (w_req) begin
                wb_dat_o <= w_rd_data;
                if (wb_we) begin
                    if (wb_adr == 3'd7) begin
                        r_bright <= wb_dat_i;
                    end else begin
                        r_row[wb_adr] <= wb_dat_i[5:0];
                    end
                end
            end

            if (w_tick) begin
                r_pre  <= '0;
                r_step <= r_step + 8'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end

            // Shadow captures the pre-write row value if a write lands on
            // this same edge, so a row never tears mid-scan.
            if (w_row_wrap) begin
                r_scan_row <= w_row_next;
                r_shadow   <= r_row[w_row_next];
            end

            charlieplex_oe <= w_oe;
            charlieplex_o  <= w_o;
        end
    end

endmodule

// File: tb/tb_charlieplex_scan.sv
module tb_charlieplex_scan;

    localparam int F = 7 * 256;   // one frame in clocks with TICKS_PER_STEP = 1

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [2:0] wb_adr = '0;
    logic [7:0] wb_dat_i = '0;
    logic [7:0] wb_dat_o;
    logic       wb_ack;
    logic [6:0] charlieplex_oe, charlieplex_o;

    int checks = 0;
    int fails  = 0;
    int n;   // posedges since reset release, tracks the DUT scan position

    typedef struct { logic is_rd; logic [7:0] dat; } bus_t;
    typedef struct { int n; logic [6:0] oe; logic [6:0] o; } pin_t;
    bus_t bus_q[$];
    pin_t pin_q[$];

    charlieplex_scan #(.TICKS_PER_STEP(1), .BRIGHTNESS_RESET(8'h40)) dut (
        .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .charlieplex_oe(charlieplex_oe), .charlieplex_o(charlieplex_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expectation for the pins sampled at the negedge after posedge idx+1,
    // i.e. reflecting scan state step = idx%256, row = (idx/256)%7.
    task automatic add_pin(input int idx, input logic [6:0] oe, input logic [6:0] o);
        pin_t e;
        e.n = idx + 1; e.oe = oe; e.o = o;
        pin_q.push_back(e);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an ack or
    // reaches a scheduled pin-sample cycle.
    always @(negedge clk) begin
        pin_t pe;
        bus_t be;
        if (!rst) begin
            while (pin_q.size() > 0 && pin_q[0].n <= n) begin
                pe = pin_q.pop_front();
                checks++;
                if (pe.n != n || charlieplex_oe !== pe.oe || charlieplex_o !== pe.o) begin
                    fails++;
                    $display("FAIL pins cyc=%0d(sched %0d) oe=%b o=%b expected oe=%b o=%b",
                             n, pe.n, charlieplex_oe, charlieplex_o, pe.oe, pe.o);
                end
            end
            if (wb_ack) begin
                checks++;
                if (bus_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_ack unexpected ack at cyc=%0d", n);
                end else begin
                    be = bus_q.pop_front();
                    if (be.is_rd && wb_dat_o !== be.dat) begin
                        fails++;
                        $display("FAIL bus_read data=%0h expected=%0h", wb_dat_o, be.dat);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic bus(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                       input logic [7:0] exp_rd);
        bus_t e;
        int lat;
        e.is_rd = ~we; e.dat = exp_rd;
        bus_q.push_back(e);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (wb_ack || lat > 8) break;
        end
        chk("ack_latency", lat, 1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        chk("ack_width", int'(wb_ack), 0);
        @(negedge clk);
    endtask

    task automatic wait_n(input int target);
        int g = 0;
        while (n < target && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_reached", int'(n >= target), 1);
    endtask

    initial begin
        int acks;
        // Pin expectations (brightness 255 in frame 1, 4 in frame 2, 0 in frame 3)
        add_pin(F + 0,         7'h00, 7'h00);   // step 0 blank
        add_pin(F + 1,         7'h03, 7'h01);   // row0 j0 -> pin1
        add_pin(F + 30,        7'h03, 7'h01);   // after mid-row write: unchanged
        add_pin(F + 255,       7'h03, 7'h01);
        add_pin(F + 768,       7'h00, 7'h00);
        add_pin(F + 769,       7'h58, 7'h08);   // row3 j3->pin4, j5->pin6
        add_pin(F + 1023,      7'h58, 7'h08);
        add_pin(2*F + 0,       7'h00, 7'h00);
        add_pin(2*F + 1,       7'h05, 7'h01);   // new row0 j1 -> pin2
        add_pin(2*F + 4,       7'h05, 7'h01);
        add_pin(2*F + 5,       7'h00, 7'h00);   // step > brightness
        add_pin(2*F + 200,     7'h00, 7'h00);
        add_pin(2*F + 768 + 1, 7'h58, 7'h08);
        add_pin(2*F + 768 + 4, 7'h58, 7'h08);
        add_pin(2*F + 768 + 5, 7'h00, 7'h00);
        for (int i = 3*F; i < 4*F; i++) add_pin(i, 7'h00, 7'h00);   // brightness 0: dark frame
        add_pin(4*F + 30,      7'h05, 7'h01);

        repeat (3) @(negedge clk);
        chk("rst_oe", int'(charlieplex_oe), 0);
        chk("rst_o", int'(charlieplex_o), 0);
        chk("rst_ack", int'(wb_ack), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_oe", int'(charlieplex_oe), 0);
        chk("idle_o", int'(charlieplex_o), 0);
        chk("idle_ack", int'(wb_ack), 0);

        bus(1'b0, 3'd7, 8'h00, 8'h40);
        bus(1'b0, 3'd3, 8'h00, 8'h00);
        bus(1'b1, 3'd2, 8'hFF, 8'h00);
        bus(1'b0, 3'd2, 8'h00, 8'h3F);

        // Strobe held four cycles: one ack only
        begin
            bus_t e;
            e.is_rd = 1'b0; e.dat = 8'h00;
            bus_q.push_back(e);
        end
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 3'd2; wb_dat_i = 8'h15;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack) acks++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        if (wb_ack) acks++;
        chk("held_stb_acks", acks, 1);
        @(negedge clk);
        bus(1'b0, 3'd2, 8'h00, 8'h15);

        // Scan configuration, all inside frame 0 row 0
        bus(1'b1, 3'd2, 8'h00, 8'h00);
        bus(1'b1, 3'd7, 8'hFF, 8'h00);
        bus(1'b1, 3'd0, 8'h01, 8'h00);
        bus(1'b1, 3'd3, 8'h28, 8'h00);
        chk("config_in_row0", int'(n < 250), 1);

        wait_n(F + 20);
        bus(1'b1, 3'd0, 8'h02, 8'h00);        // mid-row write to the row being scanned
        wait_n(F + 1300);
        bus(1'b1, 3'd7, 8'h04, 8'h00);
        wait_n(2*F + 1300);
        bus(1'b1, 3'd7, 8'h00, 8'h00);
        wait_n(4*F + 5);
        bus(1'b1, 3'd7, 8'hFF, 8'h00);

        wait_n(4*F + 40);
        chk("pre_rst_oe", int'(charlieplex_oe), 7'h05);
        rst = 1'b1;
        #1;
        chk("async_rst_oe", int'(charlieplex_oe), 0);
        chk("async_rst_o", int'(charlieplex_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus(1'b0, 3'd0, 8'h00, 8'h00);
        bus(1'b0, 3'd7, 8'h00, 8'h40);

        repeat (2) @(negedge clk);
        chk("pin_queue_drained", pin_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/charlieplex_scan.md
Name: charlieplex_scan

Overview:
- Wishbone-slave display driver for the 7-pin charlieplexed LED matrix (7 anode rows × 6 cathode columns = 42 LEDs).
- Holds a 7-row framebuffer and a global brightness register.
- Scans one row at a time, with a blanking gap and PWM dimming.
- Its registered charlieplex_oe / charlieplex_o outputs feed the board-level tri-state SB_IO cells directly; the register bus is driven by the SPI-to-Wishbone bridge inside mTop.

Parameters:
- TICKS_PER_STEP, 16: clk cycles per PWM step; must be ≥ 1. One row dwell = 256 × TICKS_PER_STEP clocks.
- BRIGHTNESS_RESET, 8'h40: brightness register value after reset.

Ports:
- clk  input  1  system clock (48 MHz HFOSC)
- rst  input  1  asynchronous, active-high reset
- wb_cyc  input  1  Wishbone cycle
- wb_stb  input  1  Wishbone strobe
- wb_we  input  1  write enable
- wb_adr  input  3  register address
- wb_dat_i  input  8  write data
- wb_dat_o  output  8  read data
- wb_ack  output  1  transfer acknowledge
- charlieplex_oe  output  7  per-pin output enable (0 = hi-Z)
- charlieplex_o  output  7  per-pin drive level

Behaviour:
- Reset (async assert, released on a clk edge):
  - row[0..6] = 0, brightness = BRIGHTNESS_RESET.
  - wb_ack = 0, wb_dat_o = 0, charlieplex_oe = 0, charlieplex_o = 0.
  - prescaler = 0, step = 0, scan_row = 0, latched row bits = 0.
  - Reset mid-scan blanks the pins immediately (asynchronously).
- Register map:
  - adr 0..6 = row[adr], bits [5:0] valid; bits [7:6] ignored on write, read as 0.
  - adr 7 = brightness[7:0].
- Wishbone (classic, single-cycle ack):
  - When cyc & stb & !ack, ack = 1 on the next clk edge. ack is a one-cycle pulse, never asserted twice for one strobe.
  - Writes update the register on the same edge that raises ack.
  - wb_dat_o is valid while ack = 1 and holds its value otherwise.
  - stb without cyc is ignored.
- Scan timing:
  - prescaler counts 0..TICKS_PER_STEP-1. On wrap, step increments (8-bit, wraps 255→0).
  - When step wraps 255→0, scan_row advances 0→1→…→6→0.
- Row latch: at the clk edge where step becomes 0, row[scan_row_next] is copied into a shadow register. Register writes mid-row take effect only at the next row start (no tearing).
- Pin drive, registered, one clk after step/row change:
  - During step 0, or when step > brightness: all oe = 0 (blank). This gives a guaranteed ≥ TICKS_PER_STEP blank between rows, removing ghosting.
  - Otherwise (1 ≤ step ≤ brightness):
    - Anode pin i = scan_row: oe[i] = 1, o[i] = 1.
    - Column j (0..5) maps to pin p = (j < i) ? j : j+1. If shadow bit j = 1: oe[p] = 1, o[p] = 0; else oe[p] = 0.
    - o[p] for undriven pins = 0.
  - brightness = 0 → fully dark. brightness = 255 → driven for steps 1..255.
  - Never more than one pin with o = 1 & oe = 1.
- Simultaneous events:
  - A write to row[k] on the same edge as the row latch for row k: the latch takes the OLD value.
  - A brightness write applies from the next step comparison.

Test Plan:
- Reset, then idle → oe = 0, o = 0, ack = 0. Read adr 7 → 8'h40. Read adr 3 → 8'h00. Each ack lasts exactly 1 cycle, 1 cycle after stb.
- Write row[2] = 8'hFF, then read back → 8'h3F. Held stb/cyc for 4 cycles yields a single ack.
- TICKS_PER_STEP = 1, brightness = 255, row[0] = 6'b000001:
  - During row 0, steps 1..255: oe = 7'b0000011, o = 7'b0000001.
  - Step 0: oe = 0.
  - Rows 1..6: oe = 0.
- row[3] = 6'b101000, brightness = 255:
  - j3→pin4, j5→pin6.
  - During row 3: oe = 7'b1011000, o = 7'b0001000.
- brightness = 4:
  - Within one row, oe ≠ 0 only on steps 1..4 (4 × TICKS_PER_STEP clocks).
  - brightness = 0 → oe stays 0 for a full 7-row frame.
- Mid-row write to row[scan_row] → pins unchanged until that row's next scan. Assert rst mid-row → oe = 0 immediately (before the next clk edge).
